mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning memory read latency in cycles from mem_en to valid mem_rdata (legal 1..7).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the consecutive data-port grants allowed while fetch waits (used only under REQ-022).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports if_req in 1 (fetch request), if_addr in 32 (fetch byte address), if_rdata out 32 (fetch data), if_ack out 1 (fetch completion pulse).
REQ-006 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in 32, dm_wdata in 32, dm_rdata out 32 and dm_ack out 1, forming the data-stage port.
REQ-007 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32 and mem_rdata in 32, forming the single-port memory side.
REQ-008 SHALL have port stall out 1, high when (if_req & ~if_ack) | (dm_req & ~dm_ack); it is combinational and drives the pipeline freeze.

Function
REQ-009 SHALL implement FSM states IDLE, RD_WAIT, WR_DONE; the owner register (IF/DM) records which port holds the grant.
REQ-010 In IDLE at a rising edge, SHALL grant DM if dm_req=1, else IF if if_req=1, else remain IDLE.
REQ-011 On grant, SHALL latch the address, dm_we and dm_wdata, and drive mem_en=1 with the latched values for exactly the one following cycle.
REQ-012 For a read grant, SHALL enter RD_WAIT with a latency counter loaded to LAT, decremented each cycle.
REQ-013 When the counter reaches 0, SHALL capture mem_rdata into the owner's rdata register, pulse the owner's ack for one cycle, and return to IDLE.
REQ-014 For a write grant (dm_we=1), SHALL enter WR_DONE, pulse dm_ack in the cycle after mem_en, and return to IDLE; dm_rdata is unchanged.
REQ-015 Read latency from grant edge to ack SHALL be LAT+1 cycles, and write latency SHALL be 1 cycle.
REQ-016 The cycle after any ack SHALL be IDLE, so a pending request is regranted at the next edge (one bubble minimum between transactions).
REQ-017 if_rdata/dm_rdata SHALL hold their last captured value until the next ack of the same port.
REQ-018 Deassertion of req before ack SHALL NOT abort the transaction; the ack is still issued.
REQ-019 Changes of addr/wdata after grant SHALL be ignored.
REQ-020 if_ack and dm_ack SHALL never be high in the same cycle.

Reset
REQ-021 Asserting reset at any time, including mid-transaction, SHALL immediately force the following: state IDLE; counters 0; mem_en, mem_we, if_ack, dm_ack 0; mem_addr, mem_wdata, if_rdata, dm_rdata 0; owner DM. No ack is issued for an interrupted transaction.

Configuration
REQ-022 With MEM_ARB_STARVE_GUARD_EN defined, SHALL count consecutive DM grants made while if_req=1; when the count equals STARVE_MAX and if_req=1, the next grant SHALL go to IF; the count SHALL clear on any IF grant or whenever if_req=0.
REQ-023 Without MEM_ARB_STARVE_GUARD_EN, arbitration SHALL be strict DM priority, and no starvation counter SHALL exist.

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, the owner encoding (OWN_IF/OWN_DM) and the address/data width constant (32).
REQ-025 The latency counter SHALL be a sub-module, arb_lat_counter (load, decrement, zero flag); everything else stays in mem_arbiter.

Verification
REQ-026 LAT=2, if_req only with if_addr=0x10, where the memory returns 0x2008000A -> mem_en one cycle after the grant edge; if_ack at grant+3 with if_rdata=0x2008000A; stall=0 in the ack cycle.
REQ-027 if_req and dm_req (read, 0x100) asserted together -> DM is granted first; dm_ack at grant+3; the IF grant follows the bubble; if_ack 4 cycles after dm_ack.
REQ-028 dm_req write with addr 0x20 and wdata 0xFFFFFFFB -> mem_we=1, mem_wdata=0xFFFFFFFB for one cycle; dm_ack the next cycle; dm_rdata unchanged.
REQ-029 reset pulsed at RD_WAIT counter=1 -> no ack, all outputs 0, state IDLE; a request held through reset is regranted at the first edge after release.
REQ-030 With MEM_ARB_STARVE_GUARD_EN and STARVE_MAX=4, dm_req held continuously and if_req=1 -> exactly 4 DM grants, then 1 IF grant, repeating; without the macro, if_ack never pulses.
REQ-031 The bench SHALL check every cycle that if_ack and dm_ack are never high simultaneously and that mem_en is never high for two consecutive cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter_pkg : shared encodings and widths for the memory arbiter    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package mem_arbiter_pkg;

    localparam int XLEN  = 32;
    localparam int LAT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_lat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb_lat_counter : loadable down-counter with zero flag (read latency)   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module arb_lat_counter
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [LAT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter : fetch/data port arbiter onto one single-port memory        |
// | Optional: MEM_ARB_STARVE_GUARD_EN bounds DM grants while fetch waits.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ack,

    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic [XLEN-1:0] dm_rdata,
    output logic            dm_ack,

    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,

    output logic            stall
);

    if ((LAT < 1) || (LAT > 7)) begin : g_lat_range
        $error("mem_arbiter: LAT must be in 1..7");
    end
    if (STARVE_MAX < 0) begin : g_starve_range
        $error("mem_arbiter: STARVE_MAX must be non-negative");
    end

    state_t          state, state_n;
    owner_t          owner, owner_n;
    logic [XLEN-1:0] addr_n, wdata_n, if_rdata_n, dm_rdata_n;
    logic            en_n, we_n, if_ack_n, dm_ack_n;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic            grant_dm;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 2);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;

    assign starve_hit = if_req && (starve_cnt == STARVE_W'(STARVE_MAX));
    assign grant_dm   = dm_req && !starve_hit;

    // Counts DM wins while fetch is waiting; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req) begin
            starve_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (grant_dm) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`else
    assign grant_dm = dm_req;
`endif

    arb_lat_counter u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT_W'(LAT)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign stall = (if_req & ~if_ack) | (dm_req & ~dm_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_DM;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            mem_en    <= en_n;
            mem_we    <= we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            if_ack    <= if_ack_n;
            dm_ack    <= dm_ack_n;
            if_rdata  <= if_rdata_n;
            dm_rdata  <= dm_rdata_n;
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        addr_n     = mem_addr;
        wdata_n    = mem_wdata;
        en_n       = 1'b0;
        we_n       = 1'b0;
        if_ack_n   = 1'b0;
        dm_ack_n   = 1'b0;
        if_rdata_n = if_rdata;
        dm_rdata_n = dm_rdata;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (grant_dm) begin
                    owner_n = OWN_DM;
                    addr_n  = dm_addr;
                    wdata_n = dm_wdata;
                    en_n    = 1'b1;
                    we_n    = dm_we;
                    if (dm_we) begin
                        state_n = ST_WR_DONE;
                    end else begin
                        state_n  = ST_RD_WAIT;
                        cnt_load = 1'b1;
                    end
                end else if (if_req) begin
                    owner_n  = OWN_IF;
                    addr_n   = if_addr;
                    en_n     = 1'b1;
                    state_n  = ST_RD_WAIT;
                    cnt_load = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_zero) begin
                    state_n = ST_IDLE;
                    if (owner == OWN_DM) begin
                        dm_rdata_n = mem_rdata;
                        dm_ack_n   = 1'b1;
                    end else begin
                        if_rdata_n = mem_rdata;
                        if_ack_n   = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WR_DONE: begin
                dm_ack_n = 1'b1;
                state_n  = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter : randomized self-checking bench for mem_arbiter         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int SM  = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct {
        int          c;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
    } grant_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    grant_t      gq[$];
    int          if_ack_n = 0, dm_ack_n = 0;
    int          if_ack_cyc, dm_ack_cyc;
    logic [31:0] if_ack_data, dm_ack_data;
    logic        prev_en = 1'b0;
    logic [31:0] last_if, last_dm;
    logic [31:0] ref_mem [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        return (idx == 8'd4) ? 32'h2008000A : (({24'h0, idx} * 32'h01000193) ^ 32'hA5C30000);
    endfunction

    // Memory device: read data is valid exactly LAT cycles after the mem_en cycle, garbage otherwise.
    logic [31:0] dev_mem [0:255];
    logic        dev_wr  [0:255];
    logic        pv [0:LAT-1];
    logic [31:0] pd [0:LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            dev_mem[mem_addr[9:2]] <= mem_wdata;
            dev_wr[mem_addr[9:2]]  <= 1'b1;
        end
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
        pv[0] <= mem_en && !mem_we;
        pd[0] <= (dev_wr[mem_addr[9:2]] === 1'b1) ? dev_mem[mem_addr[9:2]] : init_word(mem_addr[9:2]);
    end

    assign mem_rdata = (pv[LAT-1] === 1'b1) ? pd[LAT-1] : 32'hBAD0BAD0;

    always @(negedge clk) begin
        total++;
        if (if_ack === 1'b1 && dm_ack === 1'b1) begin
            bad++;
            $display("FAIL ack_overlap: got if_ack=1 dm_ack=1 want at most one high (cyc %0d)", cyc);
        end
        total++;
        if (mem_en === 1'b1 && prev_en === 1'b1) begin
            bad++;
            $display("FAIL mem_en_pair: got mem_en high two cycles want single-cycle pulse (cyc %0d)", cyc);
        end
        prev_en = mem_en;
        if (mem_en === 1'b1) gq.push_back('{cyc, mem_addr, mem_we, mem_wdata});
        if (if_ack === 1'b1) begin
            if_ack_n++;
            if_ack_cyc  = cyc;
            if_ack_data = if_rdata;
        end
        if (dm_ack === 1'b1) begin
            dm_ack_n++;
            dm_ack_cyc  = cyc;
            dm_ack_data = dm_rdata;
        end
    end

    // One transaction per requested port; expected timeline derived from the arbitration rules.
    task automatic do_txn(input string name, input bit want_if, input bit want_dm, input bit we,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                          input bit drop_early);
        int k, ig, iack, dg, dack, last, q0, ifn0, dmn0;
        logic [31:0] exp_if_d, exp_dm_d, exp_ifr, exp_dmr;
        bit exp_st;
        grant_t g;
        @(negedge clk);
        k = cyc; ig = -1; iack = -1; dg = -1; dack = -1;
        exp_dm_d = last_dm;
        if (want_dm) begin
            dg   = k + 1;
            dack = dg + (we ? 1 : LAT + 1);
            if (we) ref_mem[da[9:2]] = wd;
            else    exp_dm_d = ref_mem[da[9:2]];
        end
        exp_if_d = last_if;
        if (want_if) begin
            ig       = want_dm ? dack + 1 : k + 1;
            iack     = ig + LAT + 1;
            exp_if_d = ref_mem[ia[9:2]];
        end
        last = (iack > dack) ? iack : dack;
        q0 = gq.size(); ifn0 = if_ack_n; dmn0 = dm_ack_n;
        if_req = want_if; if_addr = ia;
        dm_req = want_dm; dm_we = we; dm_addr = da; dm_wdata = wd;
        for (int c = k + 1; c <= last + 1; c++) begin
            @(negedge clk);
            exp_st = (if_req && cyc != iack) || (dm_req && cyc != dack);
            total++;
            if (stall !== exp_st) begin
                bad++;
                $display("FAIL %s stall: got %b want %b (cyc %0d)", name, stall, exp_st, cyc);
            end
            exp_ifr = (want_if && cyc >= iack) ? exp_if_d : last_if;
            total++;
            if (if_rdata !== exp_ifr) begin
                bad++;
                $display("FAIL %s if_rdata: got %h want %h (cyc %0d)", name, if_rdata, exp_ifr, cyc);
            end
            exp_dmr = (want_dm && cyc >= dack) ? exp_dm_d : last_dm;
            total++;
            if (dm_rdata !== exp_dmr) begin
                bad++;
                $display("FAIL %s dm_rdata: got %h want %h (cyc %0d)", name, dm_rdata, exp_dmr, cyc);
            end
            if (cyc == iack || (drop_early && cyc == ig)) if_req = 1'b0;
            if (cyc == dack || (drop_early && cyc == dg)) dm_req = 1'b0;
            if (want_if && cyc >= ig) if_addr = $urandom;
            if (want_dm && cyc >= dg) begin
                dm_addr  = $urandom;
                dm_wdata = $urandom;
            end
        end
        #1;
        total++;
        if (gq.size() - q0 !== int'(want_if) + int'(want_dm)) begin
            bad++;
            $display("FAIL %s grant_cnt: got %0d want %0d", name, gq.size() - q0, int'(want_if) + int'(want_dm));
        end
        if (want_dm && gq.size() > q0) begin
            g = gq[q0]; q0++;
            total++;
            if (g.c !== dg || g.a !== da || g.w !== we || (we && g.d !== wd)) begin
                bad++;
                $display("FAIL %s dm_grant: got cyc=%0d addr=%h we=%b wd=%h want cyc=%0d addr=%h we=%b wd=%h",
                         name, g.c, g.a, g.w, g.d, dg, da, we, wd);
            end
        end
        if (want_if && gq.size() > q0) begin
            g = gq[q0];
            total++;
            if (g.c !== ig || g.a !== ia || g.w !== 1'b0) begin
                bad++;
                $display("FAIL %s if_grant: got cyc=%0d addr=%h we=%b want cyc=%0d addr=%h we=0",
                         name, g.c, g.a, g.w, ig, ia);
            end
        end
        gq.delete();
        total++;
        if (if_ack_n - ifn0 !== int'(want_if) || dm_ack_n - dmn0 !== int'(want_dm)) begin
            bad++;
            $display("FAIL %s ack_cnt: got if=%0d dm=%0d want if=%0d dm=%0d",
                     name, if_ack_n - ifn0, dm_ack_n - dmn0, want_if, want_dm);
        end
        if (want_if) begin
            total++;
            if (if_ack_cyc !== iack || if_ack_data !== exp_if_d) begin
                bad++;
                $display("FAIL %s if_ack: got cyc=%0d data=%h want cyc=%0d data=%h",
                         name, if_ack_cyc, if_ack_data, iack, exp_if_d);
            end
        end
        if (want_dm) begin
            total++;
            if (dm_ack_cyc !== dack || dm_ack_data !== exp_dm_d) begin
                bad++;
                $display("FAIL %s dm_ack: got cyc=%0d data=%h want cyc=%0d data=%h",
                         name, dm_ack_cyc, dm_ack_data, dack, exp_dm_d);
            end
        end
        last_if = exp_if_d;
        last_dm = exp_dm_d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({mem_en, mem_we, if_ack, dm_ack, stall, mem_addr, mem_wdata, if_rdata, dm_rdata} !== 133'd0) begin
            bad++;
            $display("FAIL reset_state: got en=%b we=%b ifa=%b dma=%b st=%b addr=%h wd=%h ifr=%h dmr=%h want all 0",
                     mem_en, mem_we, if_ack, dm_ack, stall, mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        reset = 1'b0;
        last_if = '0;
        last_dm = '0;
        gq.delete();
    endtask

    task automatic test_fetch();
        do_txn("fetch", 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
        total++;
        if (if_rdata !== 32'h2008000A) begin
            bad++;
            $display("FAIL fetch_data: got %h want 2008000a", if_rdata);
        end
    endtask

    task automatic test_priority();
        do_txn("prio", 1'b1, 1'b1, 1'b0, 32'h30, 32'h100, 32'h0, 1'b0);
        total++;
        if (if_ack_cyc - dm_ack_cyc !== LAT + 2) begin
            bad++;
            $display("FAIL prio_gap: got %0d want %0d", if_ack_cyc - dm_ack_cyc, LAT + 2);
        end
    endtask

    task automatic test_write();
        do_txn("write", 1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'hFFFFFFFB, 1'b0);
        do_txn("write_rb", 1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 1'b0);
        total++;
        if (dm_rdata !== 32'hFFFFFFFB) begin
            bad++;
            $display("FAIL write_readback: got %h want fffffffb", dm_rdata);
        end
        do_txn("drop_early", 1'b1, 1'b1, 1'b0, 32'h54, 32'h58, 32'h0, 1'b1);
    endtask

    task automatic test_mid_reset();
        int k, g, r, ack_c, dmn0;
        logic [31:0] exp_d;
        @(negedge clk);
        gq.delete();
        k = cyc; dmn0 = dm_ack_n;
        if_req = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
        g = k + 1;
        exp_d = ref_mem[8'h11];
        while (cyc < g + LAT - 1) @(negedge clk);
        total++;
        if (gq.size() !== 1 || dm_ack_n !== dmn0) begin
            bad++;
            $display("FAIL midrst_pre: got grants=%0d acks=%0d want grants=1 acks=0", gq.size(), dm_ack_n - dmn0);
        end
        gq.delete();
        reset = 1'b1;
        #1;
        total++;
        if ({mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata} !== 132'd0) begin
            bad++;
            $display("FAIL midrst_outputs: got en=%b we=%b ifa=%b dma=%b addr=%h wd=%h ifr=%h dmr=%h want all 0",
                     mem_en, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        r = cyc;
        ack_c = r + 1 + LAT + 1;
        for (int c = r + 1; c <= ack_c; c++) begin
            @(negedge clk);
            if (cyc == ack_c) dm_req = 1'b0;
        end
        #1;
        total++;
        if (dm_ack_n - dmn0 !== 1 || dm_ack_cyc !== ack_c || dm_ack_data !== exp_d) begin
            bad++;
            $display("FAIL midrst_regrant: got acks=%0d cyc=%0d data=%h want acks=1 cyc=%0d data=%h",
                     dm_ack_n - dmn0, dm_ack_cyc, dm_ack_data, ack_c, exp_d);
        end
        total++;
        if (gq.size() !== 1 || (gq.size() > 0 && gq[0].c !== r + 1) || if_rdata !== 32'h0) begin
            bad++;
            $display("FAIL midrst_grant: got grants=%0d if_rdata=%h want 1 grant at cyc %0d if_rdata=0",
                     gq.size(), if_rdata, r + 1);
        end
        gq.delete();
        last_dm = exp_d;
        last_if = '0;
    endtask

    task automatic test_starve();
        int k, n, ifn0, exp_acks;
        bit exp_if;
        n = 3 * (SM + 1);
        @(negedge clk);
        gq.delete();
        k = cyc; ifn0 = if_ack_n;
        if_addr = 32'h40; dm_addr = 32'h80; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        for (int c = 0; c < n * (LAT + 2) + 10 && gq.size() < n; c++) @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        #1;
        total++;
        if (gq.size() !== n) begin
            bad++;
            $display("FAIL starve_grant_cnt: got %0d want %0d", gq.size(), n);
        end
        for (int i = 0; i < n && i < gq.size(); i++) begin
            exp_if = GUARD && ((i % (SM + 1)) == SM);
            total++;
            if (gq[i].a !== (exp_if ? 32'h40 : 32'h80) || gq[i].c !== k + 1 + i * (LAT + 2)) begin
                bad++;
                $display("FAIL starve_grant%0d: got addr=%h cyc=%0d want addr=%h cyc=%0d",
                         i, gq[i].a, gq[i].c, exp_if ? 32'h40 : 32'h80, k + 1 + i * (LAT + 2));
            end
        end
        exp_acks = GUARD ? n / (SM + 1) : 0;
        total++;
        if (if_ack_n - ifn0 !== exp_acks) begin
            bad++;
            $display("FAIL starve_if_acks: got %0d want %0d", if_ack_n - ifn0, exp_acks);
        end
        total++;
        if (dm_rdata !== ref_mem[8'h20]) begin
            bad++;
            $display("FAIL starve_dm_rdata: got %h want %h", dm_rdata, ref_mem[8'h20]);
        end
        gq.delete();
        last_dm = ref_mem[8'h20];
        if (GUARD) last_if = ref_mem[8'h10];
    endtask

    task automatic test_random();
        logic [1:0] sel;
        for (int it = 0; it < 40; it++) begin
            sel = 2'($urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_txn("rand", sel[0], sel[1], 1'($urandom_range(0, 1)),
                   {22'h0, 8'($urandom), 2'b00}, {22'h0, 8'($urandom), 2'b00},
                   $urandom, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_mid_reset();
        test_starve();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
